// File: rtl/encrypt_ctrl.sv
// encrypt_ctrl: iterative PRESENT-80 block cipher controller.
// One round datapath and one key-schedule datapath are shared across all
// 31 rounds. A 4-phase req/ack handshake starts an operation and returns
// the ciphertext on c. The result is valid 32 cycles after the accept edge.
// Optional feature: define ENCRYPT_CTRL_ROUND_OUT_EN to add the 5-bit rnd
// output. rnd shows the active round number while rounds are running.

package encrypt_ctrl_pkg;

    // PRESENT 4-bit S-box. Nibble x of the table holds S(x).
    localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage

// One PRESENT round: addRoundKey, then sBoxLayer, then pLayer.
module encrypt_ctrl_round (
    input  logic [63:0] state_in,
    input  logic [63:0] round_key,
    output logic [63:0] state_out
);
    import encrypt_ctrl_pkg::*;

    logic [63:0] mixed;
    logic [63:0] subbed;

    assign mixed = state_in ^ round_key;

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        assign subbed[4*n +: 4] = sbox(mixed[4*n +: 4]);
    end

    // pLayer: bit i moves to position i*16 mod 63. Bit 63 stays in place.
    for (genvar i = 0; i < 63; i++) begin : g_perm
        assign state_out[(i * 16) % 63] = subbed[i];
    end
    assign state_out[63] = subbed[63];

endmodule

// PRESENT-80 key update. The register is rotated left by 61. The top
// nibble then passes through the S-box. The round counter is XORed into
// bits [19:15].
module encrypt_ctrl_key_schedule (
    input  logic [79:0] key_in,
    input  logic [4:0]  round_ctr,
    output logic [79:0] key_out
);
    import encrypt_ctrl_pkg::*;

    logic [79:0] rotated;

    assign rotated = {key_in[18:0], key_in[79:19]};

    // Apply the S-box and the counter XOR on top of the rotated key.
    always_comb begin
        key_out         = rotated;
        key_out[79:76]  = sbox(rotated[79:76]);
        key_out[19:15]  = rotated[19:15] ^ round_ctr;
    end

endmodule

module encrypt_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] k,
    input  logic [63:0] m,
    output logic [63:0] c,
    input  logic        req,
    output logic        ack,
    output logic        busy
`ifdef ENCRYPT_CTRL_ROUND_OUT_EN
    ,
    output logic [4:0]  rnd
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_t;

    fsm_t        fsm;
    logic [63:0] state;
    logic [79:0] key;
    logic [4:0]  rc;
    logic [63:0] state_next;
    logic [79:0] key_next;

    encrypt_ctrl_round u_round (
        .state_in  (state),
        .round_key (key[79:16]),
        .state_out (state_next)
    );

    encrypt_ctrl_key_schedule u_key_schedule (
        .key_in    (key),
        .round_ctr (rc),
        .key_out   (key_next)
    );

    // Handshake FSM, datapath registers and registered outputs.
    // busy (and rnd) are loaded alongside the state transitions, so they
    // track the ROUND/FINAL states without a combinational decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm   <= IDLE;
            state <= '0;
            key   <= '0;
            rc    <= '0;
            c     <= '0;
            ack   <= 1'b0;
            busy  <= 1'b0;
`ifdef ENCRYPT_CTRL_ROUND_OUT_EN
            rnd   <= '0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    if (req) begin
                        state <= m;
                        key   <= k;
                        rc    <= 5'd1;
                        busy  <= 1'b1;
`ifdef ENCRYPT_CTRL_ROUND_OUT_EN
                        rnd   <= 5'd1;
`endif
                        fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    state <= state_next;
                    key   <= key_next;
                    rc    <= rc + 5'd1;
                    if (rc == 5'd31) begin
                        fsm <= FINAL;
`ifdef ENCRYPT_CTRL_ROUND_OUT_EN
                        rnd <= '0;
`endif
                    end else begin
`ifdef ENCRYPT_CTRL_ROUND_OUT_EN
                        rnd <= rc + 5'd1;
`endif
                    end
                end
                FINAL: begin
                    c    <= state ^ key[79:16];
                    ack  <= 1'b1;
                    busy <= 1'b0;
                    fsm  <= DONE;
                end
                DONE: begin
                    if (!req) begin
                        ack <= 1'b0;
                        fsm <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/encrypt_ctrl.md
ENCRYPT_CTRL -- requirements
Module: encrypt_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide: k  input  `N_K (80)  cipher key; stable while req=1.
REQ-004 SHALL provide: m  input  `N_B (64)  plaintext; stable while req=1.
REQ-005 SHALL provide: c  output  `N_B (64)  ciphertext register.
REQ-006 SHALL provide: req  input  1  start request, 4-phase handshake.
REQ-007 SHALL provide: ack  output  1  result valid / handshake acknowledge, registered.
REQ-008 SHALL provide: busy  output  1  high in LOAD-excluded states ROUND and FINAL.

Function
REQ-009 SHALL implement iterative PRESENT-80 encryption with exactly one round instance and one key_schedule instance, reused every cycle.
REQ-010 SHALL hold registers: state (64b), key (80b), rc (5b round counter), fsm state.
REQ-011 SHALL have FSM states IDLE, ROUND, FINAL, DONE; reset state IDLE.
REQ-012 IDLE with req=1 at edge: state<=m, key<=k, rc<=1, go ROUND; req=0: stay.
REQ-013 ROUND each edge: state<=round(state,key); key<=key_schedule(key,rc); rc<=rc+1.
REQ-014 ROUND with rc=31 at edge: perform round 31 as REQ-013, go FINAL (rc not wrapped to 0 into use).
REQ-015 FINAL edge: c<=state XOR key[79:16]; ack<=1; go DONE.
REQ-016 Latency: req sampled at edge E0 -> ack=1 and c valid after edge E32 (32 cycles); exactly 31 rounds.
REQ-017 DONE: ack held 1 while req=1; on edge with req=0: ack<=0, go IDLE.
REQ-018 req deasserted during ROUND/FINAL SHALL be ignored; operation completes, ack pulses exactly one cycle.
REQ-019 New request SHALL be accepted only from IDLE; no restart while ack=1 (req must return low first).
REQ-020 c SHALL hold last result until next FINAL; k/m changes outside IDLE-accept edge have no effect.
REQ-021 busy SHALL be 1 exactly in ROUND and FINAL (32 cycles per operation).

Reset
REQ-022 rst=1 at edge SHALL force IDLE, ack=0, c=0, state=0, key=0, rc=0, from any state including mid-round.
REQ-023 rst SHALL dominate req in the same cycle; req still high after rst release starts a new operation on next edge.

Configuration
REQ-024 Macro ENCRYPT_CTRL_ROUND_OUT_EN defined: extra output port rnd (5b) = rc in ROUND, 0 elsewhere; reset 0.
REQ-025 Macro ENCRYPT_CTRL_ROUND_OUT_EN undefined: rnd port absent; all other behaviour identical.

Verification
REQ-026 k=0, m=0, req held high -> ack rises 32 cycles after accept edge, c=5579C1387B228445.
REQ-027 k=FFFFFFFFFFFFFFFFFFFF, m=0 -> c=E72C46C0F5945049; k=0, m=FFFFFFFFFFFFFFFF -> c=A112FFC72F68417B.
REQ-028 k=all ones, m=all ones, req dropped after 1 cycle -> ack one-cycle pulse at cycle 32, c=3333DCD3213210D2, busy=1 for 32 cycles.
REQ-029 rst at round 15 of an operation -> next cycle ack=0, c=0, busy=0; fresh req yields correct c with full 32-cycle latency.
REQ-030 Back-to-back: req held high through DONE -> no second start; after req low one cycle then high, second vector completes correctly; changing k/m mid-operation does not alter c.
